adc_capture: RTL
================

# adc_capture

Receive-side counterpart of the DAC output path. Accepts the 256-bit sample stream from the RFSoC ADC IP and captures a programmed number of beats once armed and triggered. The captured beats are buffered in an internal FIFO and delivered to the PS as a single framed AXI-Stream packet, with `tlast` on the final beat. It sits between the RFSoC ADC AXIS output and the PS DMA, and shares the GPIO control word and `trigger_in`/`select_in` fabric with the DAC driver.

## Interface
- `mem_width`, 16, log2 of capture FIFO depth in beats; must be ≥ 12.
- `clk`  in  1  sample-domain clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `gpio_ctrl_ext`  in  16  control word, registered once internally:
  - [0] arm;
  - [1] force trigger;
  - [3:2] reserved;
  - [15:4] length−1 in beats.
- `s_axis_tdata`  in  256  ADC samples (16 × 16-bit).
- `s_axis_tvalid`  in  1  ADC beat valid.
- `s_axis_tready`  out  1  constant 1 out of reset. The ADC is never stalled.
- `m_axis_tdata`  out  256  captured beat to PS.
- `m_axis_tvalid`  out  1  FIFO non-empty.
- `m_axis_tlast`  out  1  final beat of capture.
- `m_axis_tready`  in  1  PS accepts.
- `trigger_in`  in  1  external trigger, level-sampled.
- `select_in`  in  1  channel select; the trigger is honoured only when this is high.
- `busy`  out  1  state ≠ IDLE.
- `overflow`  out  1  sticky; the FIFO was full during capture.
- `done`  out  1  one-cycle pulse when the final beat is written.

## Operation
- `gpio_ctrl` ← `gpio_ctrl_ext` every cycle. An arm edge is `gpio_ctrl[0]` rising, compared against its own registered copy.
- States:
  - IDLE → ARMED on arm edge. This clears `overflow` and loads the beat counter with `gpio_ctrl[15:4]`. Length field 0 captures 1 beat; 0xFFF captures 4096 beats.
  - ARMED → CAPTURE when (`trigger_in` & `select_in`) | `gpio_ctrl[1]`.
  - ARMED → IDLE if `gpio_ctrl[0]` is sampled low (disarm).
  - CAPTURE: every cycle with `s_axis_tvalid`=1, write {last, tdata} to the FIFO and decrement the counter. `last` = (counter == 0).
  - CAPTURE → IDLE on the write with last=1, with `done`=1 that cycle.
  - CAPTURE, FIFO full on a valid beat: the beat is dropped, `overflow`←1 and the capture aborts (→ IDLE, no `done`). The packet already in the FIFO carries no `tlast`; software must reset the block.
- Edge handling:
  - An arm edge outside IDLE is ignored.
  - Trigger in IDLE or CAPTURE is ignored.
  - Deasserting arm during CAPTURE does not abort.
  - `s_axis_tvalid`=0 cycles in CAPTURE are skipped; they do not count.
- Output side: standard AXIS. A beat transfers when `m_axis_tvalid` & `m_axis_tready`. Data and `tlast` are held stable while valid and not ready.
- The FIFO drains concurrently with capture; PS backpressure only matters through FIFO fullness.
- Reset, including mid-capture or mid-drain, gives:
  - state IDLE, counter 0, FIFO flushed;
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0;
  - `busy`=0, `overflow`=0, `done`=0, `s_axis_tready`=0 while `rst` is high.

## Timing
- GPIO to state: an edge on `gpio_ctrl_ext[0]` at cycle N gives ARMED at N+2 (one cycle register, one cycle edge detect).
- Trigger sampled high at cycle T in ARMED: state is CAPTURE at T+1. The first captured beat is the valid beat at T+1; the beat present at T is not captured.
- Write to output: a beat written at cycle W is visible on `m_axis_*` at W+1 at the earliest (registered first-word-fall-through read).
- Full check: uses the FIFO count before the write, so a simultaneous read and write when full still counts as an overflow. This is deliberately conservative.
- `done` and the last write occur in the same cycle. `busy` falls in the following cycle.
- Throughput: 1 beat/cycle in and out, no bubbles.

## Structure
- Add to `rfsoc_config`:
  - `adc_cap_state_t` enum {IDLE, ARMED, CAPTURE};
  - GPIO bit constants `ADC_GPIO_ARM`=0, `ADC_GPIO_FORCE`=1, `ADC_GPIO_LEN_LSB`=4, `ADC_GPIO_LEN_MSB`=15;
  - `AXIS_BEAT_W`=256.
- Sub-module `adc_capture_fifo`:
  - 257-bit wide (`tlast` + data), depth 2^`mem_width`, first-word-fall-through;
  - exposes full, empty and count;
  - asynchronous reset clears the pointers.
- The FSM, counter and flags live in `adc_capture`.

## Test plan
- Length 8 (field 7), arm, pulse `trigger_in` with `select_in`=1, continuous ADC valid with data = beat index 0..15 → PS receives beats 1..8 (the first valid after the trigger), `tlast` on beat 8 only, `done` one pulse, `busy` 0 afterwards.
- Trigger with `select_in`=0 → stays ARMED, nothing written. Then `gpio[1]`=1 → capture starts on the next cycle.
- Length 4, ADC valid pattern 1,0,1,0… → exactly 4 beats captured over 7 cycles, `tlast` on the 4th.
- `mem_width`=12 (4096-beat FIFO), length 4096, `m_axis_tready`=0 throughout → all 4096 beats stored with no overflow. Repeat with `tready`=0 and length field set so a 4097th beat would be needed (second capture without draining) → `overflow`=1, state IDLE, no `done`.
- Assert `rst` mid-capture after 3 beats → all outputs return to reset values immediately, FIFO empty. A fresh arm/trigger then captures normally.
- Arm edge while in CAPTURE → ignored, counter unaffected. Disarm in ARMED → IDLE, a later trigger is ignored.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// ---------------------------------------------------------------------------
// adc_capture_pkg
//   Shared types and constants for the ADC capture path.
//   - adc_cap_state_t : capture FSM states
//   - ADC_GPIO_*      : bit positions inside the GPIO control word
//   - AXIS_BEAT_W     : width of one AXI-Stream sample beat
//   - ADC_LEN_W       : width of the length-minus-one field
//   - ADC_FIFO_W      : FIFO word width ({tlast, tdata})
// ---------------------------------------------------------------------------
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } adc_cap_state_t;

  localparam int ADC_GPIO_ARM     = 0;
  localparam int ADC_GPIO_FORCE   = 1;
  localparam int ADC_GPIO_LEN_LSB = 4;
  localparam int ADC_GPIO_LEN_MSB = 15;

  localparam int AXIS_BEAT_W = 256;
  localparam int ADC_LEN_W   = ADC_GPIO_LEN_MSB - ADC_GPIO_LEN_LSB + 1;
  localparam int ADC_FIFO_W  = AXIS_BEAT_W + 1;

endpackage

// File: rtl/adc_capture_fifo.sv
// ---------------------------------------------------------------------------
// adc_capture_fifo
//   First-word-fall-through FIFO holding {tlast, tdata} beats. Storage is an
//   inferred RAM plus one output register; the total number of beats held
//   (RAM + output register) never exceeds 2**ADDR_W.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset (flushes the FIFO)
//   wr_en      push wr_data (ignored when full)
//   wr_data    ADC_FIFO_W-bit word
//   rd_en      consumer accepts the head word (when rd_valid)
//   rd_data    head word, held stable until consumed
//   rd_valid   head word present
//   full       2**ADDR_W beats held
//   empty      nothing held
//   count      beats held, 0 .. 2**ADDR_W
// ---------------------------------------------------------------------------
module adc_capture_fifo
  import adc_capture_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADC_FIFO_W-1:0] wr_data,
  input  logic                  rd_en,
  output logic [ADC_FIFO_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADC_FIFO_W-1:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0]     wr_ptr_reg;
  logic [ADDR_W-1:0]     rd_ptr_reg;
  logic [ADDR_W:0]       ram_cnt_reg;
  logic                  out_valid_reg;
  logic [ADC_FIFO_W-1:0] out_data_reg;

  logic wr_accept;
  logic pop;
  logic load_out;
  logic ram_empty;
  logic ram_re;
  logic bypass;
  logic ram_we;

  assign wr_accept = wr_en & ~full;
  assign pop       = out_valid_reg & rd_en;
  // The output register may take a new word when it is empty or being consumed.
  assign load_out  = ~out_valid_reg | pop;
  assign ram_empty = (ram_cnt_reg == '0);
  assign ram_re    = load_out & ~ram_empty;
  // With nothing queued in RAM, a new beat goes straight into the output
  // register so it is visible on the next cycle.
  assign bypass    = load_out & ram_empty & wr_accept;
  assign ram_we    = wr_accept & ~bypass;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      ram_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (ram_we) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (ram_re) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      case ({ram_we, ram_re})
        2'b10:   ram_cnt_reg <= ram_cnt_reg + (ADDR_W + 1)'(1);
        2'b01:   ram_cnt_reg <= ram_cnt_reg - (ADDR_W + 1)'(1);
        default: ram_cnt_reg <= ram_cnt_reg;
      endcase
      if (load_out) begin
        if (ram_re) begin
          out_data_reg  <= mem[rd_ptr_reg];
          out_valid_reg <= 1'b1;
        end else if (bypass) begin
          out_data_reg  <= wr_data;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign count    = ram_cnt_reg + {{ADDR_W{1'b0}}, out_valid_reg};
  assign full     = (count == DEPTH_CNT);
  assign empty    = ~out_valid_reg;
  assign rd_valid = out_valid_reg;
  assign rd_data  = out_data_reg;

endmodule

// File: rtl/adc_capture.sv
// ---------------------------------------------------------------------------
// adc_capture
//   Captures a programmed number of ADC beats after arm + trigger and sends
//   them to the PS as one AXI-Stream packet with tlast on the final beat.
//
// Ports
//   clk, rst          sample clock, asynchronous active-high reset
//   gpio_ctrl_ext     [0] arm, [1] force trigger, [15:4] length-1 (beats)
//   s_axis_*          ADC input stream; tready is 1 out of reset
//   m_axis_*          captured packet to the PS DMA
//   trigger_in        external trigger, honoured only with select_in high
//   select_in         channel select
//   busy              FSM not idle
//   overflow          sticky, a beat arrived while the FIFO was full
//   done              one-cycle pulse on the final beat write
// ---------------------------------------------------------------------------
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int mem_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            gpio_ctrl_ext,
  input  logic [AXIS_BEAT_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [AXIS_BEAT_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  input  logic                   trigger_in,
  input  logic                   select_in,
  output logic                   busy,
  output logic                   overflow,
  output logic                   done
);

  adc_cap_state_t state_reg, state_next;

  logic [15:0]          gpio_ctrl_reg;
  logic                 arm_prev_reg;
  logic [ADC_LEN_W-1:0] beat_cnt_reg;
  logic                 overflow_reg;
  logic                 tready_reg;

  logic arm_edge;
  logic trig;
  logic cnt_zero;
  logic load_cnt;
  logic dec_cnt;
  logic ovf_set;
  logic ovf_clr;
  logic fifo_wr;
  logic done_next;

  logic [ADC_FIFO_W-1:0] fifo_rd_data;
  logic                  fifo_rd_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [mem_width:0]    fifo_count;

  // Reserved GPIO bits, the FIFO valid duplicate and the occupancy count are
  // not needed by the control path; they are folded here to keep them visible.
  logic unused_bits;
  assign unused_bits = ^{gpio_ctrl_reg[3:2], fifo_rd_valid, fifo_count};

  // GPIO word is registered once; the arm edge compares against a second copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_ctrl_reg <= '0;
      arm_prev_reg  <= 1'b0;
      tready_reg    <= 1'b0;
    end else begin
      gpio_ctrl_reg <= gpio_ctrl_ext;
      arm_prev_reg  <= gpio_ctrl_reg[ADC_GPIO_ARM];
      tready_reg    <= 1'b1;
    end
  end

  assign arm_edge = gpio_ctrl_reg[ADC_GPIO_ARM] & ~arm_prev_reg;
  assign trig     = (trigger_in & select_in) | gpio_ctrl_reg[ADC_GPIO_FORCE];
  assign cnt_zero = (beat_cnt_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    ovf_set    = 1'b0;
    ovf_clr    = 1'b0;
    fifo_wr    = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arm_edge) begin
          state_next = ARMED;
          load_cnt   = 1'b1;
          ovf_clr    = 1'b1;
        end
      end
      ARMED: begin
        // A trigger wins over a simultaneous disarm.
        if (trig) begin
          state_next = CAPTURE;
        end else if (!gpio_ctrl_reg[ADC_GPIO_ARM]) begin
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        if (s_axis_tvalid) begin
          // Fullness is judged before any same-cycle read, so a beat that
          // meets a full FIFO aborts even if the PS is draining.
          if (fifo_full) begin
            ovf_set    = 1'b1;
            state_next = IDLE;
          end else begin
            fifo_wr = 1'b1;
            if (cnt_zero) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              dec_cnt = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (load_cnt) begin
        beat_cnt_reg <= gpio_ctrl_reg[ADC_GPIO_LEN_MSB:ADC_GPIO_LEN_LSB];
      end else if (dec_cnt) begin
        beat_cnt_reg <= beat_cnt_reg - ADC_LEN_W'(1);
      end
      if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end else if (ovf_set) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  adc_capture_fifo #(
    .ADDR_W (mem_width)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  ({cnt_zero, s_axis_tdata}),
    .rd_en    (m_axis_tready),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_rd_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign s_axis_tready = tready_reg;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tlast  = fifo_rd_data[AXIS_BEAT_W];
  assign m_axis_tdata  = fifo_rd_data[AXIS_BEAT_W-1:0];
  assign busy          = (state_reg != IDLE);
  assign overflow      = overflow_reg;
  assign done          = done_next;

endmodule
